memory_stage: RTL

- Pipeline MEM stage: the consumer of the EX/ME pipeline register outputs.
- Non-memory instructions pass their ALU result straight to the ME/WB register.
- Loads and stores run a multi-cycle req/ack transaction on the data-memory port and stall upstream until it completes or times out.
- Also drives the MEM-stage bypass value to the EX forwarding muxes, and the registered writeback bundle to the WB stage.

---
 rtl/memory_stage_pkg.sv | 6 +
 rtl/memory_stage_dmem_req_fsm.sv | 79 +++++++
 rtl/memory_stage.sv | 60 ++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared types and constants for the MEM pipeline stage
package memory_stage_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  typedef enum logic {IDLE, REQ} state_t;
endpackage

// File: rtl/memory_stage_dmem_req_fsm.sv
// memory_stage_dmem_req_fsm: data-memory req/ack sequencer with timeout, request capture and stall
// Ports: clk/rst (async active-low); EX/ME fields in; dmem_ack in; stall, pass (non-mem op in IDLE),
// done (ack in REQ), dmem_req/we/addr/wdata, captured rd/reg_we/mem_to_reg, sticky error flags out.
module memory_stage_dmem_req_fsm
  import memory_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      rd,
  input  logic            mem_we,
  input  logic            mem_to_reg,
  input  logic            reg_we,
  input  logic            dmem_ack,
  output logic            stall,
  output logic            pass,
  output logic            done,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [4:0]      cap_rd,
  output logic            cap_reg_we,
  output logic            cap_mem_to_reg,
  output logic            err_timeout,
  output logic            err_misalign
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic mem_op, idle, last, misalign, start, expire;
  assign mem_op   = in_valid & (mem_we | mem_to_reg);
  assign idle     = state == IDLE;
  assign last     = cnt == CW'(TIMEOUT - 1);
  assign misalign = idle & mem_op & |(alu_out[1:0] & ALIGN_MASK);
  assign start    = idle & mem_op & !misalign;
  assign pass     = idle & in_valid & !mem_op;
  // ack beats timeout when both land in the same cycle
  assign done     = !idle & dmem_ack;
  assign expire   = !idle & !dmem_ack & last;
  // request is a pure function of state so async reset drops it at once
  assign dmem_req = !idle;
  always_comb begin
    state_nx = start ? REQ : (!idle & (dmem_ack | last)) ? IDLE : state;
    stall    = start | (!idle & !dmem_ack & !last);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      cap_rd         <= '0;
      cap_reg_we     <= 1'b0;
      cap_mem_to_reg <= 1'b0;
      err_timeout    <= 1'b0;
      err_misalign   <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= start ? '0 : !idle ? cnt + 1'b1 : cnt;
      err_timeout  <= err_timeout | expire;
      err_misalign <= err_misalign | misalign;
      if (start) begin
        dmem_we        <= mem_we;
        dmem_addr      <= alu_out;
        dmem_wdata     <= wd;
        cap_rd         <= rd;
        cap_reg_we     <= reg_we;
        cap_mem_to_reg <= mem_to_reg;
      end
    end
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage -- ME/WB register, EX bypass and data-memory access
// Ports: clk/rst (async active-low); EX/ME fields (in_valid, alu_out, wd, rd, mem_we, mem_to_reg, reg_we);
// stall and bp_mem upstream; dmem_* memory port; wb_data/wb_rd/wb_we to WB; sticky err_timeout/err_misalign.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      rd,
  input  logic            mem_we,
  input  logic            mem_to_reg,
  input  logic            reg_we,
  output logic            stall,
  output logic [XLEN-1:0] bp_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            err_timeout,
  output logic            err_misalign
);
  logic pass, done, cap_reg_we, cap_mem_to_reg;
  logic [4:0] cap_rd;
  assign bp_mem = alu_out;
  memory_stage_dmem_req_fsm #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) u_fsm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_out(alu_out), .wd(wd), .rd(rd),
    .mem_we(mem_we), .mem_to_reg(mem_to_reg), .reg_we(reg_we), .dmem_ack(dmem_ack),
    .stall(stall), .pass(pass), .done(done), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .cap_rd(cap_rd), .cap_reg_we(cap_reg_we),
    .cap_mem_to_reg(cap_mem_to_reg), .err_timeout(err_timeout), .err_misalign(err_misalign)
  );
  // every cycle that is neither a completion nor an ALU pass puts a bubble into WB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data <= '0;
      wb_rd   <= '0;
      wb_we   <= 1'b0;
    end else begin
      wb_we <= done ? cap_reg_we : pass & reg_we;
      if (done) begin
        wb_data <= cap_mem_to_reg ? dmem_rdata : dmem_addr;
        wb_rd   <= cap_rd;
      end else if (pass) begin
        wb_data <= alu_out;
        wb_rd   <= rd;
      end
    end
  end
endmodule
